// File: rtl/axi_rd_arbiter.sv
// Two-requester AXI4 read-channel arbiter (requester 0 = IFU, requester 1 = LSU).
// Round-robin grant, one outstanding burst; the grant is locked from AR issue
// until the last R beat handshakes. Write channels do not pass through here.
module axi_rd_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clock,
    input  logic              reset,
    // Requester 0
    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic              m0_arvalid,
    input  logic [7:0]        m0_arlen,
    input  logic [2:0]        m0_arsize,
    output logic              m0_arready_o,
    input  logic              m0_rready,
    output logic [DATA_W-1:0] m0_rdata_o,
    output logic [1:0]        m0_rresp_o,
    output logic              m0_rvalid_o,
    output logic              m0_rlast_o,
    // Requester 1
    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic              m1_arvalid,
    input  logic [7:0]        m1_arlen,
    input  logic [2:0]        m1_arsize,
    output logic              m1_arready_o,
    input  logic              m1_rready,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic [1:0]        m1_rresp_o,
    output logic              m1_rvalid_o,
    output logic              m1_rlast_o,
    // Downstream read master port
    output logic [ADDR_W-1:0] araddr_o,
    output logic              arvalid_o,
    output logic [3:0]        arid_o,
    output logic [7:0]        arlen_o,
    output logic [2:0]        arsize_o,
    output logic [1:0]        arburst_o,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    input  logic              rlast,
    output logic              rready_o
);

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    state_e state_q;
    logic   grant_q;
    logic   last_grant_q;
    logic   r_done;

    // Last beat of the locked burst handshakes this cycle.
    assign r_done    = rvalid & rready_o & rlast;
    assign arburst_o = 2'b01;

    // Arbitration FSM; last_grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    if (m0_arvalid || m1_arvalid) begin
                        grant_q <= (m0_arvalid && m1_arvalid) ? ~last_grant_q : m1_arvalid;
                        state_q <= StAddr;
                    end
                end
                StAddr: begin
                    if (arready) state_q <= StData;
                end
                StData: begin
                    if (r_done) begin
                        state_q      <= StIdle;
                        last_grant_q <= grant_q;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Route AR from and R to the granted requester; everything else reads zero.
    always_comb begin
        araddr_o     = '0;
        arvalid_o    = 1'b0;
        arid_o       = 4'd0;
        arlen_o      = 8'd0;
        arsize_o     = 3'd0;
        rready_o     = 1'b0;
        m0_arready_o = 1'b0;
        m1_arready_o = 1'b0;
        m0_rdata_o   = '0;
        m1_rdata_o   = '0;
        m0_rresp_o   = 2'b00;
        m1_rresp_o   = 2'b00;
        m0_rvalid_o  = 1'b0;
        m1_rvalid_o  = 1'b0;
        m0_rlast_o   = 1'b0;
        m1_rlast_o   = 1'b0;
        case (state_q)
            StAddr: begin
                arvalid_o = 1'b1;
                arid_o    = {3'b000, grant_q};
                if (grant_q) begin
                    araddr_o     = m1_araddr;
                    arlen_o      = m1_arlen;
                    arsize_o     = m1_arsize;
                    m1_arready_o = arready;
                end else begin
                    araddr_o     = m0_araddr;
                    arlen_o      = m0_arlen;
                    arsize_o     = m0_arsize;
                    m0_arready_o = arready;
                end
            end
            StData: begin
                if (grant_q) begin
                    rready_o    = m1_rready;
                    m1_rvalid_o = rvalid;
                    m1_rdata_o  = rdata;
                    m1_rresp_o  = rresp;
                    m1_rlast_o  = rlast;
                end else begin
                    rready_o    = m0_rready;
                    m0_rvalid_o = rvalid;
                    m0_rdata_o  = rdata;
                    m0_rresp_o  = rresp;
                    m0_rlast_o  = rlast;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter. Inputs change on the falling edge and
// outputs are sampled 1ns later, well away from the rising (active) edge.
module tb_axi_rd_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 64;

    logic              clock;
    logic              reset;
    logic [ADDR_W-1:0] m0_araddr, m1_araddr;
    logic              m0_arvalid, m1_arvalid;
    logic [7:0]        m0_arlen, m1_arlen;
    logic [2:0]        m0_arsize, m1_arsize;
    logic              m0_arready_o, m1_arready_o;
    logic              m0_rready, m1_rready;
    logic [DATA_W-1:0] m0_rdata_o, m1_rdata_o;
    logic [1:0]        m0_rresp_o, m1_rresp_o;
    logic              m0_rvalid_o, m1_rvalid_o;
    logic              m0_rlast_o, m1_rlast_o;
    logic [ADDR_W-1:0] araddr_o;
    logic              arvalid_o;
    logic [3:0]        arid_o;
    logic [7:0]        arlen_o;
    logic [2:0]        arsize_o;
    logic [1:0]        arburst_o;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rlast;
    logic              rready_o;

    int n_checks = 0;
    int n_fail   = 0;

    axi_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock(clock), .reset(reset),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arlen(m0_arlen),
        .m0_arsize(m0_arsize), .m0_arready_o(m0_arready_o), .m0_rready(m0_rready),
        .m0_rdata_o(m0_rdata_o), .m0_rresp_o(m0_rresp_o), .m0_rvalid_o(m0_rvalid_o),
        .m0_rlast_o(m0_rlast_o),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arlen(m1_arlen),
        .m1_arsize(m1_arsize), .m1_arready_o(m1_arready_o), .m1_rready(m1_rready),
        .m1_rdata_o(m1_rdata_o), .m1_rresp_o(m1_rresp_o), .m1_rvalid_o(m1_rvalid_o),
        .m1_rlast_o(m1_rlast_o),
        .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arid_o(arid_o), .arlen_o(arlen_o),
        .arsize_o(arsize_o), .arburst_o(arburst_o), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rlast(rlast), .rready_o(rready_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic clear_inputs();
        m0_araddr = '0; m1_araddr = '0; m0_arvalid = 0; m1_arvalid = 0;
        m0_arlen = 0; m1_arlen = 0; m0_arsize = 0; m1_arsize = 0;
        m0_rready = 0; m1_rready = 0; arready = 0; rdata = '0; rresp = 0;
        rvalid = 0; rlast = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        @(negedge clock); #1;
        n_checks++; if (arvalid_o !== 1'b0) begin n_fail++; $display("FAIL rst_arvalid got %0h want 0", arvalid_o); end
        n_checks++; if (arburst_o !== 2'b01) begin n_fail++; $display("FAIL rst_arburst got %0h want 1", arburst_o); end
        n_checks++; if (rready_o !== 1'b0) begin n_fail++; $display("FAIL rst_rready got %0h want 0", rready_o); end
        n_checks++; if (arid_o !== 4'd0) begin n_fail++; $display("FAIL rst_arid got %0h want 0", arid_o); end
        @(negedge clock); reset = 1'b1;
    endtask

    task automatic test_single_m0();
        @(negedge clock);
        m0_arvalid = 1; m0_araddr = 32'h8000_0000; m0_arlen = 0; m0_arsize = 3; #1;
        n_checks++; if (arvalid_o !== 1'b0) begin n_fail++; $display("FAIL single_idle_arvalid got %0h want 0", arvalid_o); end
        @(negedge clock); arready = 1; #1;
        n_checks++; if (arvalid_o !== 1'b1) begin n_fail++; $display("FAIL single_arvalid got %0h want 1", arvalid_o); end
        n_checks++; if (araddr_o !== 32'h8000_0000) begin n_fail++; $display("FAIL single_araddr got %0h want 80000000", araddr_o); end
        n_checks++; if (arid_o !== 4'd0) begin n_fail++; $display("FAIL single_arid got %0h want 0", arid_o); end
        n_checks++; if (arsize_o !== 3'd3) begin n_fail++; $display("FAIL single_arsize got %0h want 3", arsize_o); end
        n_checks++; if (m0_arready_o !== 1'b1) begin n_fail++; $display("FAIL single_m0_arready got %0h want 1", m0_arready_o); end
        @(negedge clock);
        arready = 0; m0_arvalid = 0; m0_rready = 1;
        rvalid = 1; rdata = 64'h1122_3344_5566_7788; rlast = 1; #1;
        n_checks++; if (m0_rvalid_o !== 1'b1) begin n_fail++; $display("FAIL single_m0_rvalid got %0h want 1", m0_rvalid_o); end
        n_checks++; if (m0_rdata_o !== 64'h1122_3344_5566_7788) begin n_fail++; $display("FAIL single_m0_rdata got %0h want 1122334455667788", m0_rdata_o); end
        n_checks++; if (m0_rlast_o !== 1'b1) begin n_fail++; $display("FAIL single_m0_rlast got %0h want 1", m0_rlast_o); end
        n_checks++; if (m1_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL single_m1_rvalid got %0h want 0", m1_rvalid_o); end
        n_checks++; if (m1_rdata_o !== 64'd0) begin n_fail++; $display("FAIL single_m1_rdata got %0h want 0", m1_rdata_o); end
        n_checks++; if (rready_o !== 1'b1) begin n_fail++; $display("FAIL single_rready got %0h want 1", rready_o); end
        // Back in IDLE: a stray rvalid must not be accepted or routed.
        @(negedge clock); rlast = 0; #1;
        n_checks++; if (rready_o !== 1'b0) begin n_fail++; $display("FAIL single_idle_rready got %0h want 0", rready_o); end
        n_checks++; if (m0_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL single_idle_rvalid got %0h want 0", m0_rvalid_o); end
        rvalid = 0; m0_rready = 0;
    endtask

    task automatic test_round_robin();
        // Fresh reset so the first tie goes to requester 0.
        @(negedge clock); reset = 0; #1; @(negedge clock); reset = 1;
        m0_arvalid = 1; m1_arvalid = 1; m0_araddr = 32'h1000; m1_araddr = 32'h2000;
        m0_rready = 1; m1_rready = 1; m0_arlen = 0; m1_arlen = 0;
        for (int k = 0; k < 8; k++) begin
            logic       exp_g;
            logic [31:0] exp_a;
            exp_g = k[0];
            exp_a = exp_g ? 32'h2000 : 32'h1000;
            #1;
            n_checks++; if (arvalid_o !== 1'b0) begin n_fail++; $display("FAIL rr_idle_arvalid k=%0d got %0h want 0", k, arvalid_o); end
            @(negedge clock); arready = 1; #1;
            n_checks++; if (arid_o !== {3'b000, exp_g}) begin n_fail++; $display("FAIL rr_arid k=%0d got %0h want %0h", k, arid_o, exp_g); end
            n_checks++; if (araddr_o !== exp_a) begin n_fail++; $display("FAIL rr_araddr k=%0d got %0h want %0h", k, araddr_o, exp_a); end
            n_checks++; if ({m1_arready_o, m0_arready_o} !== (exp_g ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL rr_arready k=%0d got %0b want %0b", k, {m1_arready_o, m0_arready_o}, (exp_g ? 2'b10 : 2'b01)); end
            @(negedge clock); arready = 0; rvalid = 1; rlast = 1; rdata = 64'(k); #1;
            n_checks++; if ({m1_rvalid_o, m0_rvalid_o} !== (exp_g ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL rr_rvalid k=%0d got %0b want %0b", k, {m1_rvalid_o, m0_rvalid_o}, (exp_g ? 2'b10 : 2'b01)); end
            @(negedge clock); rvalid = 0; rlast = 0;
        end
        m0_arvalid = 0; m1_arvalid = 0; m0_rready = 0; m1_rready = 0;
    endtask

    task automatic test_burst4_m1();
        @(negedge clock);
        m1_arvalid = 1; m1_araddr = 32'h3000; m1_arlen = 3; m1_arsize = 3;
        @(negedge clock); arready = 1; #1;
        n_checks++; if (arlen_o !== 8'd3) begin n_fail++; $display("FAIL b4_arlen got %0h want 3", arlen_o); end
        n_checks++; if (arsize_o !== 3'd3) begin n_fail++; $display("FAIL b4_arsize got %0h want 3", arsize_o); end
        n_checks++; if (arid_o !== 4'd1) begin n_fail++; $display("FAIL b4_arid got %0h want 1", arid_o); end
        n_checks++; if (m1_arready_o !== 1'b1) begin n_fail++; $display("FAIL b4_m1_arready got %0h want 1", m1_arready_o); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            arready = 0; m1_arvalid = 0; m0_arvalid = 1; m0_araddr = 32'h5000;
            m1_rready = 1; rvalid = 1; rdata = 64'hA0 + 64'(i); rlast = (i == 3); #1;
            n_checks++; if (m1_rdata_o !== 64'hA0 + 64'(i)) begin n_fail++; $display("FAIL b4_rdata i=%0d got %0h want %0h", i, m1_rdata_o, 64'hA0 + 64'(i)); end
            n_checks++; if (m1_rlast_o !== (i == 3)) begin n_fail++; $display("FAIL b4_rlast i=%0d got %0h want %0h", i, m1_rlast_o, (i == 3)); end
            n_checks++; if (m0_arready_o !== 1'b0) begin n_fail++; $display("FAIL b4_m0_arready i=%0d got %0h want 0", i, m0_arready_o); end
            n_checks++; if (m0_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL b4_m0_rvalid i=%0d got %0h want 0", i, m0_rvalid_o); end
        end
        @(negedge clock); rvalid = 0; rlast = 0; m1_rready = 0; arready = 1; #1;
        n_checks++; if (m0_arready_o !== 1'b0) begin n_fail++; $display("FAIL b4_idle_m0_arready got %0h want 0", m0_arready_o); end
        @(negedge clock); #1;
        n_checks++; if (m0_arready_o !== 1'b1) begin n_fail++; $display("FAIL b4_m0_granted got %0h want 1", m0_arready_o); end
        n_checks++; if (araddr_o !== 32'h5000) begin n_fail++; $display("FAIL b4_m0_araddr got %0h want 5000", araddr_o); end
        @(negedge clock); arready = 0; m0_arvalid = 0; m0_rready = 1; rvalid = 1; rlast = 1;
        @(negedge clock); rvalid = 0; rlast = 0; m0_rready = 0;
    endtask

    task automatic test_stall();
        @(negedge clock); m1_arvalid = 1; m1_araddr = 32'h4000_0040; m1_arlen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock); #1;
            n_checks++; if (arvalid_o !== 1'b1) begin n_fail++; $display("FAIL stall_arvalid i=%0d got %0h want 1", i, arvalid_o); end
            n_checks++; if (araddr_o !== 32'h4000_0040) begin n_fail++; $display("FAIL stall_araddr i=%0d got %0h want 40000040", i, araddr_o); end
            n_checks++; if (m1_arready_o !== 1'b0) begin n_fail++; $display("FAIL stall_m1_arready i=%0d got %0h want 0", i, m1_arready_o); end
        end
        @(negedge clock); arready = 1; #1;
        n_checks++; if (m1_arready_o !== 1'b1) begin n_fail++; $display("FAIL stall_accept got %0h want 1", m1_arready_o); end
        @(negedge clock); arready = 0; m1_arvalid = 0; rvalid = 1; rlast = 1; rdata = 64'hDEAD_BEEF_0000_0001;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (rready_o !== 1'b0) begin n_fail++; $display("FAIL stall_rready_low i=%0d got %0h want 0", i, rready_o); end
            n_checks++; if (m1_rvalid_o !== 1'b1) begin n_fail++; $display("FAIL stall_beat_held i=%0d got %0h want 1", i, m1_rvalid_o); end
            @(negedge clock);
        end
        m1_rready = 1; #1;
        n_checks++; if (rready_o !== 1'b1) begin n_fail++; $display("FAIL stall_rready_high got %0h want 1", rready_o); end
        n_checks++; if (m1_rdata_o !== 64'hDEAD_BEEF_0000_0001) begin n_fail++; $display("FAIL stall_rdata got %0h want deadbeef00000001", m1_rdata_o); end
        @(negedge clock); rvalid = 0; rlast = 0; m1_rready = 0; #1;
        n_checks++; if (m1_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL stall_idle_rvalid got %0h want 0", m1_rvalid_o); end
    endtask

    task automatic test_slverr();
        @(negedge clock); m0_arvalid = 1; m0_araddr = 32'h6000; m0_arlen = 0;
        @(negedge clock); arready = 1;
        @(negedge clock); arready = 0; m0_arvalid = 0; m0_rready = 1; rvalid = 1; rlast = 1; rresp = 2'b10; #1;
        n_checks++; if (m0_rresp_o !== 2'b10) begin n_fail++; $display("FAIL err_rresp got %0h want 2", m0_rresp_o); end
        n_checks++; if (m1_rresp_o !== 2'b00) begin n_fail++; $display("FAIL err_m1_rresp got %0h want 0", m1_rresp_o); end
        @(negedge clock); rvalid = 0; rlast = 0; rresp = 0; m0_rready = 0; m1_arvalid = 1; m1_araddr = 32'h7000; #1;
        n_checks++; if (arvalid_o !== 1'b0) begin n_fail++; $display("FAIL err_idle got %0h want 0", arvalid_o); end
        @(negedge clock); arready = 1; #1;
        n_checks++; if (arid_o !== 4'd1) begin n_fail++; $display("FAIL err_next_arid got %0h want 1", arid_o); end
        @(negedge clock); arready = 0; m1_arvalid = 0; m1_rready = 1; rvalid = 1; rlast = 1;
        @(negedge clock); rvalid = 0; rlast = 0; m1_rready = 0;
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clock); m0_arvalid = 1; m0_araddr = 32'h9000; m0_arlen = 3;
        @(negedge clock); arready = 1;
        @(negedge clock); arready = 0; m0_arvalid = 0; m0_rready = 1; rvalid = 1; rlast = 0; rdata = 64'h55; #1;
        n_checks++; if (m0_rvalid_o !== 1'b1) begin n_fail++; $display("FAIL rmid_beat0 got %0h want 1", m0_rvalid_o); end
        @(negedge clock); reset = 0; #1;
        n_checks++; if (m0_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rmid_rvalid got %0h want 0", m0_rvalid_o); end
        n_checks++; if (rready_o !== 1'b0) begin n_fail++; $display("FAIL rmid_rready got %0h want 0", rready_o); end
        n_checks++; if (m0_rdata_o !== 64'd0) begin n_fail++; $display("FAIL rmid_rdata got %0h want 0", m0_rdata_o); end
        @(negedge clock); reset = 1; rvalid = 0; m0_rready = 0; m1_arvalid = 1; m1_araddr = 32'hA000; m1_arlen = 0;
        @(negedge clock); arready = 1; #1;
        n_checks++; if (arid_o !== 4'd1) begin n_fail++; $display("FAIL rmid_m1_arid got %0h want 1", arid_o); end
        @(negedge clock); arready = 0; m1_arvalid = 0; m1_rready = 1; rvalid = 1; rlast = 1;
        // m1 just finished, so a tie now goes to m0.
        @(negedge clock); rvalid = 0; rlast = 0; m1_rready = 0; m0_arvalid = 1; m1_arvalid = 1;
        @(negedge clock); #1;
        n_checks++; if (arid_o !== 4'd0) begin n_fail++; $display("FAIL rmid_tie_arid got %0h want 0", arid_o); end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single_m0();
        test_round_robin();
        test_burst4_m1();
        test_stall();
        test_slverr();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
